stage_fetch: RTL

Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of the decode stage. Owns the PC and issues sequential word fetches to instruction memory over a valid/ready request channel with an in-order, variable-latency response channel. Buffers returned instructions in a small FIFO and presents one registered instruction per cycle to decode. Honours stall from the hazard unit and redirect (taken branch/jump) from execute, discarding wrong-path responses still in flight.

---
 rtl/stage_fetch_if.sv | 24 ++
 rtl/stage_fetch.sv | 121 ++++++++++++
 2 files changed

// File: rtl/stage_fetch_if.sv
// Instruction-memory channel: valid/ready fetch requests, in-order variable-latency responses.
interface stage_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/stage_fetch.sv
// RV32I fetch stage: credit-limited sequential fetch, response FIFO, registered output (2 edges rsp->instr).
// Stall freezes the output register and FIFO head while fetching continues within credit; redirect flushes.
module stage_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          redirect,
  input  logic [31:0]   redirect_addr,
  stage_fetch_if.master imem,
  output logic [31:0]   instr,
  output logic [31:0]   fetch_instr_addr,
  output logic [31:0]   fetch_instr_addr_plus,
  output logic          fetch_valid
);
  localparam int          CW      = $clog2(FIFO_DEPTH + 1);
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_C = CW'(1);
  localparam logic [AW-1:0] ONE_P = AW'(1);

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] fifo_count;
  logic [AW-1:0] fifo_wr;
  logic [AW-1:0] fifo_rd;
  logic [AW-1:0] aq_wr;
  logic [AW-1:0] aq_rd;
  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [31:0]   fifo_addr  [FIFO_DEPTH];
  logic [31:0]   aq_addr    [FIFO_DEPTH];

  logic          credit_ok;
  logic          accept;
  logic          rsp_take;
  logic          rsp_drop;
  logic          rsp_keep;
  logic          fifo_pop;
  logic [CW-1:0] rsp_dec;

  // Credit covers both in-flight requests and buffered instructions, so the FIFO can never overflow.
  assign credit_ok           = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_W;
  assign imem.imem_req_valid = !rst && !redirect && credit_ok;
  assign imem.imem_req_addr  = pc;

  assign accept   = imem.imem_req_valid && imem.imem_req_ready;
  assign rsp_take = imem.imem_rsp_valid && (outstanding != '0);
  assign rsp_drop = rsp_take && (discard != '0);
  assign rsp_keep = rsp_take && (discard == '0);
  assign fifo_pop = !stall && (fifo_count != '0);
  assign rsp_dec  = CW'(rsp_take);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc                    <= RESET_ADDR;
      outstanding           <= '0;
      discard               <= '0;
      fifo_count            <= '0;
      fifo_wr               <= '0;
      fifo_rd               <= '0;
      aq_wr                 <= '0;
      aq_rd                 <= '0;
      instr                 <= NOP_INSTR;
      fetch_instr_addr      <= '0;
      fetch_instr_addr_plus <= '0;
      fetch_valid           <= 1'b0;
    end else if (redirect) begin
      // Everything still in flight belongs to the old path, including a response landing now.
      pc          <= redirect_addr;
      outstanding <= outstanding - rsp_dec;
      discard     <= outstanding - rsp_dec;
      fifo_count  <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      aq_wr       <= '0;
      aq_rd       <= '0;
      instr       <= NOP_INSTR;
      fetch_valid <= 1'b0;
    end else begin
      if (accept) begin
        pc             <= pc + 32'd4;
        aq_addr[aq_wr] <= pc;
        aq_wr          <= aq_wr + ONE_P;
      end
      outstanding <= outstanding + CW'(accept) - rsp_dec;
      if (rsp_drop) begin
        discard <= discard - ONE_C;
      end
      if (rsp_keep) begin
        fifo_instr[fifo_wr] <= imem.imem_rsp_data;
        fifo_addr[fifo_wr]  <= aq_addr[aq_rd];
        fifo_wr             <= fifo_wr + ONE_P;
        aq_rd               <= aq_rd + ONE_P;
      end
      if (!stall) begin
        if (fifo_count != '0) begin
          instr                 <= fifo_instr[fifo_rd];
          fetch_instr_addr      <= fifo_addr[fifo_rd];
          fetch_instr_addr_plus <= fifo_addr[fifo_rd] + 32'd4;
          fetch_valid           <= 1'b1;
          fifo_rd               <= fifo_rd + ONE_P;
        end else begin
          instr       <= NOP_INSTR;
          fetch_valid <= 1'b0;
        end
      end
      fifo_count <= fifo_count + CW'(rsp_keep) - CW'(fifo_pop);
    end
  end

  a_rsp_with_nothing_outstanding: assert property (@(posedge clk) disable iff (rst)
    !(imem.imem_rsp_valid && (outstanding == '0)));
  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    (({1'b0, outstanding} + {1'b0, fifo_count}) <= DEPTH_W));
  a_discard_bound: assert property (@(posedge clk) disable iff (rst)
    (discard <= outstanding));
endmodule
